// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, mux selects,
// opcode classes and the packed control vector produced by the state decoder.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_ILLEGAL  = 4'd10
  } state_e;

  localparam logic [1:0] SRCA_REG    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_WD     = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;

  localparam logic [1:0] OP_DP       = 2'b00;
  localparam logic [1:0] OP_MEM      = 2'b01;
  localparam logic [1:0] OP_BR       = 2'b10;

  typedef struct packed {
    logic       next_pc;
    logic       branch;
    logic       mem_w;
    logic       reg_w;
    logic       ir_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_op;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Pure state -> control-vector decode. MemReady qualification and reset gating
// are applied by the parent FSM, so the strobes here are the unqualified values.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [3:0]  state_i,
  output logic [13:0] ctrl_o,
  output logic        illegal_o
);

  ctrl_t c;

  always_comb begin
    c         = '0;
    illegal_o = 1'b0;
    case (state_e'(state_i))
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.next_pc    = 1'b1;
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURES;
      end
      S_DECODE: begin
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURES;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_REG;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_w      = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src    = 1'b1;
        c.mem_w      = 1'b1;
        c.instr_done = 1'b1;
      end
      S_EXECUTER: begin
        c.alu_src_a = SRCA_REG;
        c.alu_src_b = SRCB_WD;
        c.alu_op    = 1'b1;
      end
      S_EXECUTEI: begin
        c.alu_src_a = SRCA_REG;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = 1'b1;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_w      = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a  = SRCA_ALUOUT;
        c.alu_src_b  = SRCB_IMM;
        c.result_src = RES_ALURES;
        c.branch     = 1'b1;
        c.instr_done = 1'b1;
      end
      S_ILLEGAL: begin
        c.instr_done = 1'b1;
        illegal_o    = 1'b1;
      end
      default: begin
        c         = '0;
        illegal_o = 1'b0;
      end
    endcase
  end

  assign ctrl_o = c;

endmodule

// File: rtl/mc_main_fsm.sv
// Main control FSM of the multicycle processor: one state per cycle, with the
// shared memory's MemReady stretching FETCH, MEMREAD and MEMWRITE.
module mc_main_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       InstrDone,
  output logic       Illegal,
  output logic [3:0] state_dbg_o
);

  state_e      state_q, state_d;
  logic [13:0] ctrl_raw;
  ctrl_t       raw;
  logic        illegal_raw;
  logic        unused_funct;

  assign unused_funct = ^Funct[4:1];

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (Op == OP_MEM)     state_d = S_MEMADR;
        else if (Op == OP_DP) state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
        else if (Op == OP_BR) state_d = S_BRANCH;
        else                  state_d = S_ILLEGAL;
      end
      S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = MemReady ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = MemReady ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  mc_ctrl_decode u_decode (
    .state_i   (state_q),
    .ctrl_o    (ctrl_raw),
    .illegal_o (illegal_raw)
  );

  assign raw = ctrl_t'(ctrl_raw);

  // Fetch strobes fire only in the cycle memory completes, so each fetch
  // produces exactly one IRWrite/NextPC; a stalled store finishes on MemReady.
  assign IRWrite   = ~reset & raw.ir_write & MemReady;
  assign NextPC    = ~reset & raw.next_pc & MemReady;
  assign InstrDone = ~reset & raw.instr_done & ((state_q != S_MEMWRITE) | MemReady);
  assign AdrSrc    = ~reset & raw.adr_src;
  assign ALUSrcA   = reset ? 2'b00 : raw.alu_src_a;
  assign ALUSrcB   = reset ? 2'b00 : raw.alu_src_b;
  assign ResultSrc = reset ? 2'b00 : raw.result_src;
  assign RegW      = ~reset & raw.reg_w;
  assign MemW      = ~reset & raw.mem_w;
  assign Branch    = ~reset & raw.branch;
  assign ALUOp     = ~reset & raw.alu_op;
  assign Illegal   = ~reset & illegal_raw;

  assign state_dbg_o = state_q;

endmodule
